// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic.
//   REG_W        : register-address width
//   state_t      : hazard FSM encoding (ST_RUN / ST_STALL)
//   MEMREAD_NONE : IDEX/EXMEM MemRead value meaning "not a load"
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [1:0] MEMREAD_NONE = 2'b00;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   Clk   : clock
//   clear : synchronous clear (wins over inc)
//   inc   : count one event this cycle
//   count : current value, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection for the 5-stage MIPS pipeline.
// Detects load-use and branch/jr operand hazards (branches resolve in ID),
// drives the ControlMux select, PC/IF-ID write enables and the IF/ID flush.
// Ports:
//   Clk, Reset (sync, active low)
//   IFID_*        : ID instruction operands and class
//   PCSrc, Jump   : taken branch / jump resolved in ID
//   IDEX_*        : EX-stage instruction (load, regwrite, destination)
//   EXMEM_*       : MEM-stage instruction (load, destination)
//   controlMuxSignal, PCWrite, IFIDWrite, IFIDFlush : pipeline controls
//   StallCycles, FlushCycles : saturating performance counters
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W      = pipeline_pkg::REG_W,
  parameter int CNT_W      = 16,
  parameter int LDBR_STALL = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_IsBranch,
  input  logic             IFID_IsJr,
  input  logic             PCSrc,
  input  logic             Jump,
  input  logic [1:0]       IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [REG_W-1:0] IDEX_WriteReg,
  input  logic [1:0]       EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_WriteReg,
  output logic             controlMuxSignal,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);

  localparam logic [1:0] LDBR_N = 2'(LDBR_STALL);

  state_t     state;
  logic [1:0] cnt;
  logic [1:0] nReq;
  logic       stall;

  logic isBrJr, rtLive, loadEx, loadMem, matchEx, matchMem;

  assign isBrJr  = IFID_IsBranch | IFID_IsJr;
  // A jr-only instruction reads rs alone, whatever UsesRt says.
  assign rtLive  = (IFID_UsesRt | IFID_IsBranch) & ~(IFID_IsJr & ~IFID_IsBranch);
  assign loadEx  = (IDEX_MemRead  != MEMREAD_NONE);
  assign loadMem = (EXMEM_MemRead != MEMREAD_NONE);

  assign matchEx  = (IDEX_WriteReg != '0) &&
                    ((IDEX_WriteReg == IFID_Rs) || (rtLive && (IDEX_WriteReg == IFID_Rt)));
  assign matchMem = (EXMEM_WriteReg != '0) &&
                    ((EXMEM_WriteReg == IFID_Rs) || (rtLive && (EXMEM_WriteReg == IFID_Rt)));

  // Required stall length; the largest applicable case wins.
  always_comb begin
    nReq = 2'd0;
    if (loadMem && matchMem && isBrJr)
      nReq = 2'd1;
    if (!loadEx && IDEX_RegWrite && matchEx && isBrJr)
      nReq = 2'd1;
    if (loadEx && matchEx && !isBrJr && (nReq < 2'd1))
      nReq = 2'd1;
    if (loadEx && matchEx && isBrJr && (LDBR_N > nReq))
      nReq = LDBR_N;
  end

  // STALL ignores hazard inputs entirely; only cnt decides when it ends.
  assign stall = (state == ST_STALL) || (nReq != 2'd0);

  always_comb begin
    controlMuxSignal = 1'b0;
    PCWrite          = 1'b0;
    IFIDWrite        = 1'b0;
    IFIDFlush        = 1'b0;
    if (Reset && !stall) begin
      controlMuxSignal = 1'b1;
      PCWrite          = 1'b1;
      IFIDWrite        = 1'b1;
      // A branch held by a stall is re-resolved here on the release cycle.
      IFIDFlush        = PCSrc | Jump | IFID_IsJr;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        ST_RUN: begin
          // N == 1 stays in RUN so the hazard is re-evaluated next cycle.
          if (nReq >= 2'd2) begin
            state <= ST_STALL;
            cnt   <= nReq - 2'd1;
          end
        end
        ST_STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt <= 2'd1)
            state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .Clk   (Clk),
    .clear (~Reset),
    .inc   (Reset & stall),
    .count (StallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .Clk   (Clk),
    .clear (~Reset),
    .inc   (IFIDFlush),
    .count (FlushCycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [REG_W-1:0] IFID_Rs, IFID_Rt, IDEX_WriteReg, EXMEM_WriteReg;
  logic             IFID_UsesRt, IFID_IsBranch, IFID_IsJr, PCSrc, Jump, IDEX_RegWrite;
  logic [1:0]       IDEX_MemRead, EXMEM_MemRead;
  logic             controlMuxSignal, PCWrite, IFIDWrite, IFIDFlush;
  logic [CNT_W-1:0] StallCycles, FlushCycles;

  hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W), .LDBR_STALL(2)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .IFID_Rs          (IFID_Rs),
    .IFID_Rt          (IFID_Rt),
    .IFID_UsesRt      (IFID_UsesRt),
    .IFID_IsBranch    (IFID_IsBranch),
    .IFID_IsJr        (IFID_IsJr),
    .PCSrc            (PCSrc),
    .Jump             (Jump),
    .IDEX_MemRead     (IDEX_MemRead),
    .IDEX_RegWrite    (IDEX_RegWrite),
    .IDEX_WriteReg    (IDEX_WriteReg),
    .EXMEM_MemRead    (EXMEM_MemRead),
    .EXMEM_WriteReg   (EXMEM_WriteReg),
    .controlMuxSignal (controlMuxSignal),
    .PCWrite          (PCWrite),
    .IFIDWrite        (IFIDWrite),
    .IFIDFlush        (IFIDFlush),
    .StallCycles      (StallCycles),
    .FlushCycles      (FlushCycles)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       cms, pcw, ifw, fl;
    int         sc, fc;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   nTot  = 0;
  int   nPass = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    nTot++;
    if (act == req) nPass++;
    else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
  endtask

  // Monitor: outputs are combinational, so each driven cycle is sampled at
  // the falling edge and checked against the oldest queued expectation.
  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      cmp(e.name, "cMS",       int'(controlMuxSignal), int'(e.cms));
      cmp(e.name, "PCWrite",   int'(PCWrite),          int'(e.pcw));
      cmp(e.name, "IFIDWrite", int'(IFIDWrite),        int'(e.ifw));
      cmp(e.name, "IFIDFlush", int'(IFIDFlush),        int'(e.fl));
      cmp(e.name, "Stall",     int'(StallCycles),      e.sc);
      cmp(e.name, "Flush",     int'(FlushCycles),      e.fc);
    end
  end

  task automatic go();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    IFID_Rs = '0; IFID_Rt = '0; IFID_UsesRt = 0; IFID_IsBranch = 0; IFID_IsJr = 0;
    PCSrc = 0; Jump = 0; IDEX_MemRead = 2'b00; IDEX_RegWrite = 0; IDEX_WriteReg = '0;
    EXMEM_MemRead = 2'b00; EXMEM_WriteReg = '0;
  endtask

  task automatic chk(input logic cms, input logic pcw, input logic ifw, input logic fl,
                     input int sc, input int fc, input string nm);
    exp_t e;
    e.cms = cms; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.sc = sc; e.fc = fc; e.name = nm;
    expQ.push_back(e);
  endtask

  task automatic ldEx(input int r);
    IDEX_MemRead = 2'b01; IDEX_RegWrite = 1; IDEX_WriteReg = REG_W'(r);
  endtask

  initial begin
    Reset = 0; clr();
    // reset: outputs forced low, counters cleared
    go(); chk(0,0,0,0, 0,0, "rst0");
    go(); ldEx(8); IFID_Rs = 8; chk(0,0,0,0, 0,0, "rst1_hazard");
    go(); Reset = 1; clr(); chk(1,1,1,0, 0,0, "idle");

    // lw $8 in EX, add reads $8 -> one stall
    go(); ldEx(8); IFID_Rs = 8; IFID_Rt = 9; IFID_UsesRt = 1;
          chk(0,0,0,0, 0,0, "lu_stall");
    go(); IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
          EXMEM_MemRead = 2'b01; EXMEM_WriteReg = 8;
          chk(1,1,1,0, 1,0, "lu_release");
    go(); clr(); chk(1,1,1,0, 1,0, "lu_after");

    // lw $9 in EX, beq $9,$10 -> two stalls via STALL state
    go(); ldEx(9); IFID_Rs = 9; IFID_Rt = 10; IFID_IsBranch = 1;
          chk(0,0,0,0, 1,0, "lb_stall1");
    go(); IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
          EXMEM_MemRead = 2'b01; EXMEM_WriteReg = 9;
          chk(0,0,0,0, 2,0, "lb_stall2");
    go(); EXMEM_MemRead = 0; EXMEM_WriteReg = 0; PCSrc = 1;
          chk(1,1,1,1, 3,0, "lb_resolve");
    go(); clr(); chk(1,1,1,0, 3,1, "lb_after");

    // add $5 in EX, jr $5 -> one stall, then flush
    go(); IDEX_RegWrite = 1; IDEX_WriteReg = 5; IFID_Rs = 5; IFID_Rt = 7; IFID_IsJr = 1;
          chk(0,0,0,0, 3,1, "jr_stall");
    go(); IDEX_RegWrite = 0; IDEX_WriteReg = 0; EXMEM_WriteReg = 5;
          chk(1,1,1,1, 4,1, "jr_release");
    go(); clr(); chk(1,1,1,0, 4,2, "jr_after");
    // jr-only ignores rt even with UsesRt set
    go(); IDEX_RegWrite = 1; IDEX_WriteReg = 7; IFID_Rs = 5; IFID_Rt = 7;
          IFID_UsesRt = 1; IFID_IsJr = 1;
          chk(1,1,1,1, 4,2, "jr_rt_ignored");
    go(); clr(); chk(1,1,1,0, 4,3, "jr_rt_after");

    // $0 never hazards
    go(); ldEx(0); IFID_Rs = 0; IFID_Rt = 0; IFID_UsesRt = 1;
          chk(1,1,1,0, 4,3, "r0_add");
    go(); IFID_UsesRt = 0; IFID_IsBranch = 1;
          chk(1,1,1,0, 4,3, "r0_beq");

    // taken branch coincident with load hazard: flush only on release
    go(); clr(); ldEx(8); IFID_Rs = 8; IFID_Rt = 3; IFID_IsBranch = 1; PCSrc = 1;
          chk(0,0,0,0, 4,3, "pc_stall1");
    go(); chk(0,0,0,0, 5,3, "pc_stall2_ignores_inputs");
    go(); IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
          chk(1,1,1,1, 6,3, "pc_release");
    go(); clr(); chk(1,1,1,0, 6,4, "pc_after");

    // load in MEM feeding a branch -> one stall
    go(); EXMEM_MemRead = 2'b10; EXMEM_WriteReg = 3; IFID_Rs = 1; IFID_Rt = 3; IFID_IsBranch = 1;
          chk(0,0,0,0, 6,4, "memld_br");
    go(); clr(); chk(1,1,1,0, 7,4, "memld_after");
    // ALU result in EX feeding a plain add: forwarded, no stall
    go(); IDEX_RegWrite = 1; IDEX_WriteReg = 4; IFID_Rs = 4;
          chk(1,1,1,0, 7,4, "alu_add_fwd");
    go(); clr(); Jump = 1; chk(1,1,1,1, 7,4, "jump");
    go(); clr(); chk(1,1,1,0, 7,5, "jump_after");

    // reset on the 1st cycle of a 2-cycle stall abandons it
    go(); ldEx(9); IFID_Rs = 9; IFID_IsBranch = 1;
          chk(0,0,0,0, 7,5, "rs_stall1");
    go(); Reset = 0; chk(0,0,0,0, 8,5, "rs_forced");
    go(); Reset = 1; clr(); chk(1,1,1,0, 0,0, "rs_release_run");

    // saturation of StallCycles at all-ones
    go(); ldEx(8); IFID_Rs = 8;
          chk(0,0,0,0, 0,0, "sat0");
    for (int i = 1; i < 20; i++) begin
      go(); chk(0,0,0,0, (i > 15) ? 15 : i, 0, $sformatf("sat%0d", i));
    end
    go(); clr(); chk(1,1,1,0, 15,0, "sat_hold");
    go(); chk(1,1,1,0, 15,0, "sat_hold2");

    begin
      int guard = 0;
      while (expQ.size() > 0 && guard < 10) begin
        @(posedge Clk); guard++;
      end
      if (expQ.size() > 0) begin
        nTot++;
        $display("FAIL drain: %0d entries left, expected 0", expQ.size());
      end
    end
    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end

endmodule
